isqrt_share_arb: RTL and testbench
==================================

Name: isqrt_share_arb

Overview:
- Shares one external pipelined isqrt instance between NREQ independent requesters, using round-robin arbitration.
- Accepts at most one operand per cycle. Each granted operand carries a requester ID through a tag pipeline that is latency-matched to isqrt. Each result is steered back to the requester that issued it.
- Sits between several formula datapaths and a single shared isqrt, so that isqrt instances do not have to be duplicated when per-requester throughput is below one per cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 16, fixed latency of the attached isqrt, from x_vld to y_vld, in cycles.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- req_vld  input  NREQ  per-requester operand valid.
- req_x  input  NREQ*32  per-requester operand; requester i uses bits [32*i+31:32*i].
- req_rdy  output  NREQ  one-hot grant; a transfer occurs when req_vld[i] & req_rdy[i].
- sq_x_vld  output  1  to isqrt x_vld.
- sq_x  output  32  to isqrt x.
- sq_y_vld  input  1  from isqrt y_vld.
- sq_y  input  16  from isqrt y.
- res_vld  output  NREQ  one-hot result valid; no backpressure.
- res  output  16  result data, shared by all requesters.
- res_id  output  IDW  ID of the result owner; meaningful only while |res_vld.
- busy  output  1  high while any tag is in flight or any output register is valid.
- err  output  1  sticky error: sq_y_vld disagreed with the tag pipeline.

Behaviour:
- Reset (rst=0, asynchronous):
  - sq_x_vld=0, sq_x=0, res_vld=0, res=0, res_id=0, err=0.
  - Tag pipeline cleared; round-robin pointer ptr=0.
  - Takes effect immediately, mid-operation included; in-flight results are discarded.
- Arbitration (combinational):
  - grant = the first asserted req_vld bit, scanning from ptr upward and wrapping modulo NREQ.
  - req_rdy = grant. req_rdy[i] is never 1 while req_vld[i]=0. At most one bit is set.
  - req_rdy=0 while rst=0.
- Pointer update: on a transfer from requester g, ptr <= (g+1) mod NREQ. With no transfer, ptr holds.
- Issue stage (registered):
  - sq_x_vld <= |(req_vld & req_rdy).
  - sq_x loads the granted operand only on a transfer and holds its value otherwise (power; no toggling on idle cycles).
- Tag pipeline: depth LAT+1 of {vld, id}.
  - Stage 0 loads {transfer, g} every cycle.
  - The id field loads only when vld=1.
  - The output stage aligns with sq_y_vld.
- Output stage (registered):
  - res_vld <= tag_vld_out ? onehot(tag_id_out) : 0.
  - res and res_id load only when tag_vld_out=1, and hold otherwise.
- Latency: a transfer in cycle t gives sq_x_vld in t+1, sq_y_vld in t+1+LAT, and res_vld in t+2+LAT. Total LAT+2 cycles, fixed.
- Throughput: one transfer per cycle sustained. Results return in issue order.
- Fairness: with all NREQ requesters permanently valid, grants rotate 0,1,..,NREQ-1,0,... A requester waits at most NREQ-1 cycles.
- Simultaneous events: a new transfer and a result return in the same cycle are independent. A requester may re-request in the cycle after its grant.
- Error: if sq_y_vld != tag_vld_out in any cycle, err <= 1 and stays 1 until reset. Output steering still follows the tag.
- busy = OR of all tag vld bits | sq_x_vld | (|res_vld).

Test Plan:
- Reset, then a single request on req 2 (x=144) at cycle 0 -> req_rdy=4'b0100 in cycle 0; sq_x_vld=1, sq_x=144 in cycle 1; res_vld=4'b0100, res=12, res_id=2 in cycle 18 (LAT=16); busy drops in cycle 19.
- All 4 requesters valid continuously from cycle 0, ptr=0 -> grants 0,1,2,3,0,1... one per cycle; results arrive in the same order back-to-back from cycle 18; err=0.
- Req 1 and req 3 valid, ptr=2 -> req 3 is granted first, then req 1; ptr ends at 2.
- Idle cycles between sparse requests -> sq_x does not change on non-transfer cycles; res/res_id hold when res_vld=0.
- Force sq_y_vld=1 for one cycle with no tag in flight -> err=1 and stays 1; res_vld remains 0.
- Assert rst=0 asynchronously mid-burst with 5 tags in flight -> all outputs are 0 immediately; after release no stale res_vld appears; a new request completes with latency 18.

Source files
------------

// File: rtl/isqrt_share_arb.sv
// isqrt_share_arb
//   Shares one external pipelined isqrt (fixed latency LAT) between NREQ
//   requesters. Grants go round-robin, at most one operand per cycle. Every
//   granted operand carries its requester ID down a tag pipeline that is
//   latency-matched to the isqrt, so each result is steered back to the
//   requester that issued it.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   req_vld   per-requester operand valid            [NREQ]
//   req_x     per-requester operand, 32b each         [NREQ*32]
//   req_rdy   one-hot grant (transfer = vld & rdy)    [NREQ]
//   sq_x_vld  operand valid to isqrt
//   sq_x      operand to isqrt                        [32]
//   sq_y_vld  result valid from isqrt
//   sq_y      result from isqrt                       [16]
//   res_vld   one-hot result valid, no backpressure   [NREQ]
//   res       result data shared by all requesters    [16]
//   res_id    owner of the current result             [IDW]
//   busy      any tag in flight or any output valid
//   err       sticky: sq_y_vld disagreed with the tag pipeline
module isqrt_share_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*32-1:0]   req_x,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 sq_x_vld,
    output logic [31:0]          sq_x,
    input  logic                 sq_y_vld,
    input  logic [15:0]          sq_y,
    output logic [NREQ-1:0]      res_vld,
    output logic [15:0]          res,
    output logic [IDW-1:0]       res_id,
    output logic                 busy,
    output logic                 err
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] cand;
    logic           found;
    logic           xfer;
    logic [31:0]    sel_x;

    // Tag stage k is valid in the same cycle the isqrt holds that operand in
    // its k-th stage; stage LAT lines up with sq_y_vld.
    logic [LAT:0]   tag_vld;
    logic [IDW-1:0] tag_id [LAT+1];

    // Round-robin scan starting at ptr. The wrap is done by subtraction rather
    // than a modulo so that non-power-of-two NREQ stays cheap.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        cand  = '0;
        sel_x = '0;
        for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
            if (32'(ptr) + k >= unsigned'(NREQ)) begin
                cand = IDW'(32'(ptr) + k - unsigned'(NREQ));
            end else begin
                cand = IDW'(32'(ptr) + k);
            end
            if (!found && req_vld[cand]) begin
                found = 1'b1;
                gid   = cand;
                sel_x = req_x[32*cand +: 32];
            end
        end
    end

    assign req_rdy = (found && rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << gid) : '0;
    assign xfer    = |(req_vld & req_rdy);

    // Pointer and issue stage; sq_x only moves on a transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            sq_x_vld <= 1'b0;
            sq_x     <= '0;
        end else begin
            sq_x_vld <= xfer;
            if (xfer) begin
                sq_x <= sel_x;
                ptr  <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            end
        end
    end

    // Tag pipeline; id fields only shift behind a valid bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k <= unsigned'(LAT); k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld <= {tag_vld[LAT-1:0], xfer};
            if (xfer) begin
                tag_id[0] <= gid;
            end
            for (int unsigned k = 1; k <= unsigned'(LAT); k++) begin
                if (tag_vld[k-1]) begin
                    tag_id[k] <= tag_id[k-1];
                end
            end
        end
    end

    // Output stage: steering follows the tag even when sq_y_vld disagrees.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld <= '0;
            res     <= '0;
            res_id  <= '0;
            err     <= 1'b0;
        end else begin
            res_vld <= tag_vld[LAT] ? ({{(NREQ-1){1'b0}}, 1'b1} << tag_id[LAT]) : '0;
            if (tag_vld[LAT]) begin
                res    <= sq_y;
                res_id <= tag_id[LAT];
            end
            if (sq_y_vld != tag_vld[LAT]) begin
                err <= 1'b1;
            end
        end
    end

    assign busy = (|tag_vld) | sq_x_vld | (|res_vld);

endmodule

// File: tb/tb_isqrt_share_arb.sv
// Self-checking bench for isqrt_share_arb (NREQ=4, LAT=16).
// A stand-in isqrt with fixed latency LAT drives sq_y/sq_y_vld; a
// transaction-level model (round-robin pointer as an integer, queue of
// expected results with due cycles) supplies every expected value.
module tb_isqrt_share_arb;
    localparam int NREQ = 4;
    localparam int LAT  = 16;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_vld;
    logic [NREQ*32-1:0]  req_x;
    logic [NREQ-1:0]     req_rdy;
    logic                sq_x_vld;
    logic [31:0]         sq_x;
    logic                sq_y_vld;
    logic [15:0]         sq_y;
    logic [NREQ-1:0]     res_vld;
    logic [15:0]         res;
    logic [IDW-1:0]      res_id;
    logic                busy;
    logic                err;
    logic                inj;

    isqrt_share_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .sq_x_vld(sq_x_vld), .sq_x(sq_x), .sq_y_vld(sq_y_vld), .sq_y(sq_y),
        .res_vld(res_vld), .res(res), .res_id(res_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int isqrt_ref(input logic [31:0] x);
        longint unsigned r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= 64'(x)) r = t;
        end
        return int'(r);
    endfunction

    // Stand-in isqrt: LAT-stage pipeline, cleared with the system reset.
    logic        pv [LAT];
    logic [15:0] py [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) begin pv[k] <= 1'b0; py[k] <= '0; end
        end else begin
            pv[0] <= sq_x_vld;
            py[0] <= 16'(isqrt_ref(sq_x));
            for (int k = 1; k < LAT; k++) begin pv[k] <= pv[k-1]; py[k] <= py[k-1]; end
        end
    end
    assign sq_y_vld = pv[LAT-1] | inj;
    assign sq_y     = py[LAT-1];

    // ---------------- reference model ----------------
    typedef struct { int id; logic [15:0] y; int due; } ent_t;
    ent_t        q[$];
    int          m_ptr, m_cyc, m_id;
    logic [15:0] m_res;
    logic [31:0] m_sqx;
    logic        m_sqv, m_err;
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++)
            if (req_vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Result due this cycle (if any) becomes the visible output state.
    task automatic model_out(output logic [NREQ-1:0] ev, output logic eb);
        ev = '0;
        if (q.size() > 0 && q[0].due == m_cyc) begin
            ev    = onehot(q[0].id);
            m_res = q[0].y;
            m_id  = q[0].id;
            void'(q.pop_front());
        end
        eb = (q.size() > 0) || (ev != 0);
    endtask

    task automatic model_commit(input int g);
        if (g >= 0) begin
            q.push_back('{id: g, y: 16'(isqrt_ref(req_x[g*32 +: 32])), due: m_cyc + LAT + 2});
            m_ptr = (g + 1) % NREQ;
            m_sqx = req_x[g*32 +: 32];
        end
        m_sqv = (g >= 0);
        if (inj) m_err = 1'b1;
        m_cyc++;
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 0; m_id = 0; m_res = '0; m_sqx = '0; m_sqv = 1'b0; m_err = 1'b0;
    endtask

    task automatic rand_x();
        for (int i = 0; i < NREQ; i++) req_x[i*32 +: 32] = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; inj = 1'b0; req_vld = '1; rand_x();
        #2;
        n_cmp++;
        if ({req_rdy, sq_x_vld, sq_x, res_vld, res, res_id, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b sxv=%b sx=%0d rv=%b res=%0d id=%0d busy=%b err=%b required all 0",
                     req_rdy, sq_x_vld, sq_x, res_vld, res, res_id, busy, err);
        end
        @(negedge clk);
        n_cmp++;
        if (req_rdy !== '0) begin
            n_fail++; $display("FAIL reset_rdy got=%b required=0000", req_rdy);
        end
        req_vld = '0;
        #2 rst = 1'b1;
        model_reset(); m_cyc = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_valid();
        logic [NREQ-1:0] ev; logic eb; int g;
        for (int c = 0; c < 12 + LAT + 4; c++) begin
            req_vld = (c < 12) ? '1 : '0;
            rand_x();
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            n_cmp++;
            if (c < 12 && req_rdy !== onehot(c % NREQ)) begin
                n_fail++; $display("FAIL rotate c=%0d got=%b required=%b", c, req_rdy, onehot(c % NREQ));
            end
            n_cmp++;
            if ({res_vld, res, res_id} !== {ev, m_res, IDW'(m_id)}) begin
                n_fail++; $display("FAIL all_valid_res c=%0d got=%b/%0d/%0d required=%b/%0d/%0d",
                                   c, res_vld, res, res_id, ev, m_res, m_id);
            end
            n_cmp++;
            if ({busy, err} !== {eb, 1'b0}) begin
                n_fail++; $display("FAIL all_valid_busy_err c=%0d got=%b%b required=%b0", c, busy, err, eb);
            end
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] ev; logic eb; int g;
        for (int c = 0; c < LAT + 5; c++) begin
            req_vld = (c == 0) ? 4'b0100 : 4'b0000;
            req_x[2*32 +: 32] = 32'd144;
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            if (c == 0) begin
                n_cmp++;
                if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_rdy got=%b required=0100", req_rdy); end
            end
            if (c == 1) begin
                n_cmp++;
                if ({sq_x_vld, sq_x} !== {1'b1, 32'd144}) begin
                    n_fail++; $display("FAIL single_issue got=%b/%0d required=1/144", sq_x_vld, sq_x);
                end
            end
            if (c == LAT + 2) begin
                n_cmp++;
                if ({res_vld, res, res_id} !== {4'b0100, 16'd12, 2'd2}) begin
                    n_fail++; $display("FAIL single_result got=%b/%0d/%0d required=0100/12/2", res_vld, res, res_id);
                end
            end
            n_cmp++;
            if ({res_vld, busy} !== {ev, eb}) begin
                n_fail++; $display("FAIL single_timing c=%0d got=%b/%b required=%b/%b", c, res_vld, busy, ev, eb);
            end
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ptr_order();
        logic [NREQ-1:0] ev; logic eb; int g;
        logic [NREQ-1:0] pat [4] = '{4'b0010, 4'b1010, 4'b1010, 4'b1111};
        logic [NREQ-1:0] exp [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b0100};
        for (int c = 0; c < LAT + 8; c++) begin
            req_vld = (c < 4) ? pat[c] : '0;
            rand_x();
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            if (c < 4) begin
                n_cmp++;
                if (req_rdy !== exp[c]) begin
                    n_fail++; $display("FAIL ptr_order c=%0d got=%b required=%b", c, req_rdy, exp[c]);
                end
            end
            n_cmp++;
            if ({res_vld, res, res_id} !== {ev, m_res, IDW'(m_id)}) begin
                n_fail++; $display("FAIL ptr_order_res c=%0d got=%b/%0d/%0d required=%b/%0d/%0d",
                                   c, res_vld, res, res_id, ev, m_res, m_id);
            end
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sparse();
        logic [NREQ-1:0] ev; logic eb; int g;
        for (int c = 0; c < 50 + LAT + 4; c++) begin
            req_vld = (c < 50 && $urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            rand_x();
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            n_cmp++;
            if (req_rdy !== onehot(g)) begin
                n_fail++; $display("FAIL sparse_rdy c=%0d got=%b required=%b", c, req_rdy, onehot(g));
            end
            n_cmp++;
            if ({sq_x_vld, sq_x} !== {m_sqv, m_sqx}) begin
                n_fail++; $display("FAIL sparse_sqx c=%0d got=%b/%h required=%b/%h", c, sq_x_vld, sq_x, m_sqv, m_sqx);
            end
            n_cmp++;
            if ({res_vld, res, res_id, busy} !== {ev, m_res, IDW'(m_id), eb}) begin
                n_fail++; $display("FAIL sparse_res c=%0d got=%b/%0d/%0d/%b required=%b/%0d/%0d/%b",
                                   c, res_vld, res, res_id, busy, ev, m_res, m_id, eb);
            end
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] ev; logic eb; int g;
        for (int c = 0; c < 60 + LAT + 4; c++) begin
            req_vld = (c < 60) ? NREQ'($urandom) : '0;
            rand_x();
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            n_cmp++;
            if (req_rdy !== onehot(g)) begin
                n_fail++; $display("FAIL b2b_rdy c=%0d got=%b required=%b", c, req_rdy, onehot(g));
            end
            n_cmp++;
            if ({res_vld, res, res_id, busy, err} !== {ev, m_res, IDW'(m_id), eb, 1'b0}) begin
                n_fail++; $display("FAIL b2b_res c=%0d got=%b/%0d/%0d/%b/%b required=%b/%0d/%0d/%b/0",
                                   c, res_vld, res, res_id, busy, err, ev, m_res, m_id, eb);
            end
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_err();
        logic [NREQ-1:0] ev; logic eb; int g;
        for (int c = 0; c < 6; c++) begin
            req_vld = '0;
            inj = (c == 1);
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            n_cmp++;
            if ({err, res_vld} !== {m_err, ev}) begin
                n_fail++; $display("FAIL err_sticky c=%0d got=%b/%b required=%b/%b", c, err, res_vld, m_err, ev);
            end
            model_commit(g);
            @(posedge clk); #1;
        end
        inj = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [NREQ-1:0] ev; logic eb; int g;
        for (int c = 0; c < 5; c++) begin
            req_vld = '1; rand_x();
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            model_commit(g);
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_rdy, sq_x_vld, sq_x, res_vld, res, res_id, busy, err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got rdy=%b sxv=%b sx=%0d rv=%b res=%0d id=%0d busy=%b err=%b required all 0",
                     req_rdy, sq_x_vld, sq_x, res_vld, res, res_id, busy, err);
        end
        model_reset();
        req_vld = '0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < LAT + 6; c++) begin
            req_vld = (c == 3) ? 4'b0001 : '0;
            rand_x();
            @(negedge clk);
            g = model_grant(); model_out(ev, eb);
            n_cmp++;
            if ({req_rdy, res_vld, res, res_id, busy, err} !== {onehot(g), ev, m_res, IDW'(m_id), eb, 1'b0}) begin
                n_fail++; $display("FAIL post_reset c=%0d got=%b/%b/%0d/%0d/%b/%b required=%b/%b/%0d/%0d/%b/0",
                                   c, req_rdy, res_vld, res, res_id, busy, err, onehot(g), ev, m_res, m_id, eb);
            end
            if (c == 3 + LAT + 2) begin
                n_cmp++;
                if (res_vld !== 4'b0001) begin
                    n_fail++; $display("FAIL post_reset_latency got=%b required=0001", res_vld);
                end
            end
            model_commit(g);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_valid();
        test_single();
        test_ptr_order();
        test_sparse();
        test_back_to_back();
        test_err();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
